// File: rtl/issue_scheduler.sv
// -----------------------------------------------------------------------------
// issue_scheduler
//
// Reservation-station scheduler for the issue stage. Holds up to RS_DEPTH
// dispatched instructions, tracks source readiness through tag wakeups from
// the complete stage, and each cycle issues the oldest ready entries:
// up to two ALU instructions (slots 0 and 1) and one MEM instruction (slot 2).
//
// Ports
//   i_clk, i_rst_n                 clock (rising edge), async active-low reset
//   i_alloc_valid / o_alloc_ready  dispatch handshake, transfer = valid & ready
//   i_alloc_is_mem                 1 = MEM class (slot 2), 0 = ALU class
//   i_alloc_payload                opaque instruction payload
//   i_alloc_tag0/1, i_alloc_rdy0/1 source tags and their already-ready flags
//   i_wake_valid, i_wake_tag       three completion wakeups (FU k at k*TAG_W)
//   i_mem_busy                     memory FU cannot take a request this cycle
//   i_flush                        synchronous clear of every entry
//   o_issue_valid                  registered per-slot issue strobes
//   o_issue_payload                registered per-slot payload (0 when idle)
//   o_count                        registered occupancy
// -----------------------------------------------------------------------------
module issue_scheduler #(
    parameter int RS_DEPTH  = 8,
    parameter int PAYLOAD_W = 64,
    parameter int TAG_W     = 6
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_alloc_valid,
    output logic                         o_alloc_ready,
    input  logic                         i_alloc_is_mem,
    input  logic [PAYLOAD_W-1:0]         i_alloc_payload,
    input  logic [TAG_W-1:0]             i_alloc_tag0,
    input  logic                         i_alloc_rdy0,
    input  logic [TAG_W-1:0]             i_alloc_tag1,
    input  logic                         i_alloc_rdy1,
    input  logic [2:0]                   i_wake_valid,
    input  logic [3*TAG_W-1:0]           i_wake_tag,
    input  logic                         i_mem_busy,
    input  logic                         i_flush,
    output logic [2:0]                   o_issue_valid,
    output logic [3*PAYLOAD_W-1:0]       o_issue_payload,
    output logic [$clog2(RS_DEPTH):0]    o_count
);

    localparam int IDX_W = $clog2(RS_DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RS_DEPTH);

    // Per-entry state
    logic [RS_DEPTH-1:0]  ent_valid;
    logic [RS_DEPTH-1:0]  ent_is_mem;
    logic [RS_DEPTH-1:0]  ent_rdy0;
    logic [RS_DEPTH-1:0]  ent_rdy1;
    logic [PAYLOAD_W-1:0] ent_payload [RS_DEPTH];
    logic [TAG_W-1:0]     ent_tag0    [RS_DEPTH];
    logic [TAG_W-1:0]     ent_tag1    [RS_DEPTH];

    // Age matrix: age_older[i][j] = 1 means entry i was allocated before j.
    // Only meaningful between valid entries; a new entry clears its row and
    // sets its column, making it younger than everything already resident.
    logic [RS_DEPTH-1:0][RS_DEPTH-1:0] age_older;

    // Select results
    logic [RS_DEPTH-1:0]  elig_alu;
    logic [RS_DEPTH-1:0]  elig_mem;
    logic [RS_DEPTH-1:0]  pick0;
    logic [RS_DEPTH-1:0]  pick1;
    logic [RS_DEPTH-1:0]  pick2;
    logic [RS_DEPTH-1:0]  issue_mask;
    logic [2:0]           issue_sel;
    logic [PAYLOAD_W-1:0] sel_pay0;
    logic [PAYLOAD_W-1:0] sel_pay1;
    logic [PAYLOAD_W-1:0] sel_pay2;

    // Allocation
    logic [IDX_W-1:0]     alloc_idx;
    logic                 alloc_fire;
    logic [CNT_W-1:0]     count_next;

    // True if tag matches any valid wakeup this cycle.
    function automatic logic wake_hit(
        input logic [TAG_W-1:0]   tag,
        input logic [2:0]         wv,
        input logic [3*TAG_W-1:0] wt
    );
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (wv[k] && (wt[k*TAG_W +: TAG_W] == tag)) hit = 1'b1;
        end
        return hit;
    endfunction

    // One-hot of the oldest candidate: a candidate survives only if it is
    // older than every other candidate.
    function automatic logic [RS_DEPTH-1:0] oldest_of(
        input logic [RS_DEPTH-1:0]                cand,
        input logic [RS_DEPTH-1:0][RS_DEPTH-1:0] older
    );
        logic [RS_DEPTH-1:0] pick;
        pick = cand;
        for (int i = 0; i < RS_DEPTH; i++) begin
            for (int j = 0; j < RS_DEPTH; j++) begin
                if (j != i && cand[j] && !older[i][j]) pick[i] = 1'b0;
            end
        end
        return pick;
    endfunction

    assign o_alloc_ready = (o_count < DEPTH_CNT);
    // A flush discards a same-cycle allocation.
    assign alloc_fire    = i_alloc_valid & o_alloc_ready & ~i_flush;

    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no path leaves a variable unassigned (no latch).
    always_comb begin
        elig_alu = '0;
        elig_mem = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            // Eligibility reads registered state only: no wakeup bypass.
            if (ent_valid[i] && ent_rdy0[i] && ent_rdy1[i]) begin
                elig_alu[i] = ~ent_is_mem[i];
                elig_mem[i] = ent_is_mem[i] & ~i_mem_busy;
            end
        end

        pick0      = oldest_of(elig_alu, age_older);
        pick1      = oldest_of(elig_alu & ~pick0, age_older);
        pick2      = oldest_of(elig_mem, age_older);
        issue_mask = pick0 | pick1 | pick2;
        issue_sel  = {|pick2, |pick1, |pick0};

        sel_pay0 = '0;
        sel_pay1 = '0;
        sel_pay2 = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (pick0[i]) sel_pay0 = sel_pay0 | ent_payload[i];
            if (pick1[i]) sel_pay1 = sel_pay1 | ent_payload[i];
            if (pick2[i]) sel_pay2 = sel_pay2 | ent_payload[i];
        end

        // Lowest-index free entry; scanning downward lets the lowest win.
        alloc_idx = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!ent_valid[i]) alloc_idx = IDX_W'(i);
        end

        count_next = o_count + CNT_W'(alloc_fire)
                   - CNT_W'(issue_sel[0]) - CNT_W'(issue_sel[1]) - CNT_W'(issue_sel[2]);
    end

    // Control state, readiness, age and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ent_valid       <= '0;
            ent_is_mem      <= '0;
            ent_rdy0        <= '0;
            ent_rdy1        <= '0;
            age_older       <= '0;
            o_issue_valid   <= '0;
            o_issue_payload <= '0;
            o_count         <= '0;
        end else if (i_flush) begin
            ent_valid       <= '0;
            o_issue_valid   <= '0;
            o_issue_payload <= '0;
            o_count         <= '0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (issue_mask[i]) begin
                    ent_valid[i] <= 1'b0;
                end else if (ent_valid[i]) begin
                    // Ready bits are sticky until the entry is freed.
                    if (wake_hit(ent_tag0[i], i_wake_valid, i_wake_tag)) ent_rdy0[i] <= 1'b1;
                    if (wake_hit(ent_tag1[i], i_wake_valid, i_wake_tag)) ent_rdy1[i] <= 1'b1;
                end
            end

            // The allocated slot is currently free, so it never collides
            // with the issue/wakeup updates above.
            if (alloc_fire) begin
                ent_valid[alloc_idx]  <= 1'b1;
                ent_is_mem[alloc_idx] <= i_alloc_is_mem;
                ent_rdy0[alloc_idx]   <= i_alloc_rdy0 | wake_hit(i_alloc_tag0, i_wake_valid, i_wake_tag);
                ent_rdy1[alloc_idx]   <= i_alloc_rdy1 | wake_hit(i_alloc_tag1, i_wake_valid, i_wake_tag);
                for (int j = 0; j < RS_DEPTH; j++) begin
                    age_older[alloc_idx][j] <= 1'b0;
                    if (IDX_W'(j) != alloc_idx) age_older[j][alloc_idx] <= 1'b1;
                end
            end

            o_issue_valid   <= issue_sel;
            o_issue_payload <= {sel_pay2, sel_pay1, sel_pay0};
            o_count         <= count_next;
        end
    end

    // NOTE: payload and tag storage has no reset; every use is gated by
    // ent_valid, so clearing these wide arrays would only cost reset fanout.
    always_ff @(posedge i_clk) begin
        if (alloc_fire) begin
            ent_payload[alloc_idx] <= i_alloc_payload;
            ent_tag0[alloc_idx]    <= i_alloc_tag0;
            ent_tag1[alloc_idx]    <= i_alloc_tag1;
        end
    end

endmodule

// File: tb/tb_issue_scheduler.sv
// -----------------------------------------------------------------------------
// tb_issue_scheduler
//
// Self-checking bench for issue_scheduler. A reference model keeps resident
// instructions in a queue ordered by allocation age and replays the
// scheduling rules each cycle; directed sequences are followed by randomized
// traffic with occasional flushes and one mid-run reset.
// -----------------------------------------------------------------------------
module tb_issue_scheduler;

    localparam int RS_DEPTH = 8;
    localparam int PW       = 64;
    localparam int TW       = 6;
    localparam int CW       = $clog2(RS_DEPTH) + 1;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic              i_alloc_valid;
    logic              o_alloc_ready;
    logic              i_alloc_is_mem;
    logic [PW-1:0]     i_alloc_payload;
    logic [TW-1:0]     i_alloc_tag0;
    logic              i_alloc_rdy0;
    logic [TW-1:0]     i_alloc_tag1;
    logic              i_alloc_rdy1;
    logic [2:0]        i_wake_valid;
    logic [3*TW-1:0]   i_wake_tag;
    logic              i_mem_busy;
    logic              i_flush;
    logic [2:0]        o_issue_valid;
    logic [3*PW-1:0]   o_issue_payload;
    logic [CW-1:0]     o_count;

    always #5 i_clk = ~i_clk;

    issue_scheduler #(
        .RS_DEPTH  (RS_DEPTH),
        .PAYLOAD_W (PW),
        .TAG_W     (TW)
    ) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_alloc_valid   (i_alloc_valid),
        .o_alloc_ready   (o_alloc_ready),
        .i_alloc_is_mem  (i_alloc_is_mem),
        .i_alloc_payload (i_alloc_payload),
        .i_alloc_tag0    (i_alloc_tag0),
        .i_alloc_rdy0    (i_alloc_rdy0),
        .i_alloc_tag1    (i_alloc_tag1),
        .i_alloc_rdy1    (i_alloc_rdy1),
        .i_wake_valid    (i_wake_valid),
        .i_wake_tag      (i_wake_tag),
        .i_mem_busy      (i_mem_busy),
        .i_flush         (i_flush),
        .o_issue_valid   (o_issue_valid),
        .o_issue_payload (o_issue_payload),
        .o_count         (o_count)
    );

    // ---------------------------------------------------------------- checking
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------- model
    typedef struct packed {
        logic          is_mem;
        logic [PW-1:0] payload;
        logic [TW-1:0] tag0;
        logic          rdy0;
        logic [TW-1:0] tag1;
        logic          rdy1;
    } ent_t;

    ent_t    rs_q[$];          // resident instructions, oldest first
    longint  seq = 0;

    function automatic logic woken(input logic [TW-1:0] tag, input logic [2:0] wv,
                                   input logic [3*TW-1:0] wt);
        for (int k = 0; k < 3; k++)
            if (wv[k] && wt[k*TW +: TW] == tag) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive_idle();
        i_alloc_valid   = 1'b0;
        i_alloc_is_mem  = 1'b0;
        i_alloc_payload = '0;
        i_alloc_tag0    = '0;
        i_alloc_rdy0    = 1'b0;
        i_alloc_tag1    = '0;
        i_alloc_rdy1    = 1'b0;
        i_wake_valid    = '0;
        i_wake_tag      = '0;
        i_mem_busy      = 1'b0;
        i_flush         = 1'b0;
    endtask

    task automatic set_alloc(input logic is_mem, input logic r0, input logic [TW-1:0] t0,
                             input logic r1, input logic [TW-1:0] t1);
        seq++;
        i_alloc_valid   = 1'b1;
        i_alloc_is_mem  = is_mem;
        i_alloc_payload = {$urandom(), 32'(seq)};
        i_alloc_rdy0    = r0;
        i_alloc_tag0    = t0;
        i_alloc_rdy1    = r1;
        i_alloc_tag1    = t1;
    endtask

    // One clock with the inputs currently driven: predict, clock, compare.
    // Called right after a falling edge; returns on the next falling edge.
    task automatic tick();
        logic          exp_ready;
        int            p0, p1, p2;
        logic [2:0]    ev;
        logic [PW-1:0] ep0, ep1, ep2;
        ent_t          nq[$];
        ent_t          e;

        exp_ready = (rs_q.size() < RS_DEPTH);
        check("alloc_ready", 64'(o_alloc_ready), 64'(exp_ready));

        p0 = -1; p1 = -1; p2 = -1;
        for (int i = 0; i < rs_q.size(); i++) begin
            if (rs_q[i].rdy0 && rs_q[i].rdy1) begin
                if (!rs_q[i].is_mem) begin
                    if (p0 < 0)      p0 = i;
                    else if (p1 < 0) p1 = i;
                end else if (!i_mem_busy && p2 < 0) begin
                    p2 = i;
                end
            end
        end

        ev = '0; ep0 = '0; ep1 = '0; ep2 = '0;
        if (i_flush) begin
            rs_q.delete();
        end else begin
            if (p0 >= 0) begin ev[0] = 1'b1; ep0 = rs_q[p0].payload; end
            if (p1 >= 0) begin ev[1] = 1'b1; ep1 = rs_q[p1].payload; end
            if (p2 >= 0) begin ev[2] = 1'b1; ep2 = rs_q[p2].payload; end
            for (int i = 0; i < rs_q.size(); i++) begin
                if (i != p0 && i != p1 && i != p2) begin
                    e = rs_q[i];
                    e.rdy0 = e.rdy0 | woken(e.tag0, i_wake_valid, i_wake_tag);
                    e.rdy1 = e.rdy1 | woken(e.tag1, i_wake_valid, i_wake_tag);
                    nq.push_back(e);
                end
            end
            if (i_alloc_valid && exp_ready) begin
                e.is_mem  = i_alloc_is_mem;
                e.payload = i_alloc_payload;
                e.tag0    = i_alloc_tag0;
                e.rdy0    = i_alloc_rdy0 | woken(i_alloc_tag0, i_wake_valid, i_wake_tag);
                e.tag1    = i_alloc_tag1;
                e.rdy1    = i_alloc_rdy1 | woken(i_alloc_tag1, i_wake_valid, i_wake_tag);
                nq.push_back(e);
            end
            rs_q = nq;
        end

        @(posedge i_clk);
        #1;
        check("issue_valid", 64'(o_issue_valid), 64'(ev));
        check("payload0", o_issue_payload[0*PW +: PW], ep0);
        check("payload1", o_issue_payload[1*PW +: PW], ep1);
        check("payload2", o_issue_payload[2*PW +: PW], ep2);
        check("count", 64'(o_count), 64'(rs_q.size()));
        @(negedge i_clk);
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            drive_idle();
            tick();
        end
    endtask

    // ---------------------------------------------------------------- stimulus
    logic [PW-1:0] pay_a;

    initial begin
        i_rst_n = 1'b0;
        drive_idle();
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_valid", 64'(o_issue_valid), 64'd0);
        check("rst_payload", 64'(|o_issue_payload), 64'd0);
        check("rst_count", 64'(o_count), 64'd0);
        check("rst_ready", 64'(o_alloc_ready), 64'd1);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Single ready ALU op: issues on slot 0 two edges after allocation.
        drive_idle();
        set_alloc(1'b0, 1'b1, 6'd1, 1'b1, 6'd2);
        pay_a = i_alloc_payload;
        tick();
        check("single_count", 64'(o_count), 64'd1);
        drive_idle();
        tick();
        check("single_valid", 64'(o_issue_valid), 64'b001);
        check("single_pay", o_issue_payload[0 +: PW], pay_a);
        idle_ticks(2);

        // Three ready ALU ops on consecutive cycles drain through slot 0.
        for (int i = 0; i < 3; i++) begin
            drive_idle();
            set_alloc(1'b0, 1'b1, 6'd0, 1'b1, 6'd0);
            tick();
        end
        idle_ticks(3);

        // A waits on tag 5, B is ready: B goes first, A after the wakeup.
        drive_idle();
        set_alloc(1'b0, 1'b1, 6'd3, 1'b0, 6'd5);
        tick();
        drive_idle();
        set_alloc(1'b0, 1'b1, 6'd3, 1'b1, 6'd4);
        tick();
        idle_ticks(2);
        drive_idle();
        i_wake_valid = 3'b100;
        i_wake_tag   = {6'd5, 6'd0, 6'd0};
        tick();
        idle_ticks(3);

        // Two MEM ops held by a busy memory FU, then released oldest first.
        for (int i = 0; i < 2; i++) begin
            drive_idle();
            set_alloc(1'b1, 1'b1, 6'd0, 1'b1, 6'd0);
            i_mem_busy = 1'b1;
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive_idle();
            i_mem_busy = 1'b1;
            tick();
            check("mem_busy_idle", 64'(o_issue_valid[2]), 64'd0);
        end
        idle_ticks(3);

        // Fill with blocked entries, attempt one more, then flush.
        for (int i = 0; i < RS_DEPTH; i++) begin
            drive_idle();
            set_alloc(i[0], 1'b0, 6'd63, 1'b1, 6'd0);
            tick();
        end
        check("full_ready", 64'(o_alloc_ready), 64'd0);
        check("full_count", 64'(o_count), 64'(RS_DEPTH));
        drive_idle();
        set_alloc(1'b0, 1'b1, 6'd0, 1'b1, 6'd0);
        tick();
        drive_idle();
        set_alloc(1'b0, 1'b1, 6'd0, 1'b1, 6'd0);
        i_wake_valid = 3'b111;
        i_wake_tag   = {6'd63, 6'd63, 6'd63};
        i_flush      = 1'b1;
        tick();
        check("flush_count", 64'(o_count), 64'd0);
        check("flush_ready", 64'(o_alloc_ready), 64'd1);
        idle_ticks(2);

        // Same-cycle wakeup captured at allocation.
        drive_idle();
        set_alloc(1'b0, 1'b0, 6'd9, 1'b1, 6'd0);
        i_wake_valid = 3'b010;
        i_wake_tag   = {6'd0, 6'd9, 6'd0};
        tick();
        drive_idle();
        tick();
        check("alloc_wake_issue", 64'(o_issue_valid), 64'b001);
        idle_ticks(2);

        // Randomized traffic with one asynchronous reset in the middle.
        for (int n = 0; n < 1500; n++) begin
            if (n == 700) begin
                i_rst_n = 1'b0;
                #1;
                check("midrst_valid", 64'(o_issue_valid), 64'd0);
                check("midrst_count", 64'(o_count), 64'd0);
                rs_q.delete();
                drive_idle();
                @(posedge i_clk);
                @(negedge i_clk);
                i_rst_n = 1'b1;
            end
            drive_idle();
            if ($urandom_range(0, 9) < 7)
                set_alloc($urandom_range(0, 2) == 0,
                          $urandom_range(0, 1) == 1, TW'($urandom_range(0, 15)),
                          $urandom_range(0, 1) == 1, TW'($urandom_range(0, 15)));
            for (int k = 0; k < 3; k++) begin
                i_wake_valid[k]        = ($urandom_range(0, 3) == 0);
                i_wake_tag[k*TW +: TW] = TW'($urandom_range(0, 15));
            end
            i_mem_busy = ($urandom_range(0, 9) < 3);
            i_flush    = ($urandom_range(0, 63) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
